// File: rtl/placement_pkg.sv
// -----------------------------------------------------------------------------
// placement_pkg
// Shared constants for the multi-program placement engine. The strip count,
// the strip width, the strip height and y-base tables and the scheduler FSM
// state encodings are defined here. The downstream (x, y) index stage reads
// the same tables, so every strip has a single definition.
// No ports (package).
// -----------------------------------------------------------------------------
package placement_pkg;

    localparam int NUM_STRIPS = 13;
    localparam int STRIP_W    = 128;

    // Scheduler FSM state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Height of strip `id` (1..13). ID 0 and out-of-range IDs return 0, so
    // they can never satisfy a fit test.
    function automatic logic [7:0] strip_height(input logic [3:0] id);
        logic [7:0] h;
        case (id)
            4'd1:    h = 8'd8;
            4'd2:    h = 8'd8;
            4'd3:    h = 8'd9;
            4'd4:    h = 8'd7;
            4'd5:    h = 8'd10;
            4'd6:    h = 8'd6;
            4'd7:    h = 8'd11;
            4'd8:    h = 8'd5;
            4'd9:    h = 8'd12;
            4'd10:   h = 8'd4;
            4'd11:   h = 8'd16;
            4'd12:   h = 8'd16;
            4'd13:   h = 8'd16;
            default: h = 8'd0;
        endcase
        return h;
    endfunction

    // Bottom y coordinate of strip `id` within the 128x128 region.
    function automatic logic [7:0] strip_ybase(input logic [3:0] id);
        logic [7:0] y;
        case (id)
            4'd1:    y = 8'd0;
            4'd2:    y = 8'd8;
            4'd3:    y = 8'd16;
            4'd4:    y = 8'd25;
            4'd5:    y = 8'd32;
            4'd6:    y = 8'd42;
            4'd7:    y = 8'd48;
            4'd8:    y = 8'd59;
            4'd9:    y = 8'd64;
            4'd10:   y = 8'd76;
            4'd11:   y = 8'd80;
            4'd12:   y = 8'd96;
            4'd13:   y = 8'd112;
            default: y = 8'd0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/strip_placement_ctrl_if.sv
// -----------------------------------------------------------------------------
// strip_placement_ctrl_if
// Request/result handshake bundle of the strip placement scheduler.
//   req_valid/req_ready/req_width/req_height : placement request channel
//   res_valid/res_ready/res_strip_id/res_occupied_width/res_strike : result
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface strip_placement_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_width;
    logic [7:0] req_height;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_strip_id;
    logic [7:0] res_occupied_width;
    logic [3:0] res_strike;

    modport master (
        output req_valid, req_width, req_height, res_ready,
        input  req_ready, res_valid, res_strip_id, res_occupied_width, res_strike
    );

    modport slave (
        input  req_valid, req_width, req_height, res_ready,
        output req_ready, res_valid, res_strip_id, res_occupied_width, res_strike
    );
endinterface

// File: rtl/strip_occ_regs.sv
// -----------------------------------------------------------------------------
// strip_occ_regs
// Per-strip occupied-width registers (IDs 1..NUM_STRIPS, 8 bits each).
//   clk, rst     : clock, synchronous active-high reset
//   clear        : synchronous clear of every entry
//   rd_idx/rd_data : combinational read port (unused IDs read as 0)
//   wr_en/wr_idx/wr_data : synchronous write port
// -----------------------------------------------------------------------------
module strip_occ_regs #(
    parameter int NUM_STRIPS = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_data,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  logic [7:0] wr_data
);

    logic [7:0] occ [1:NUM_STRIPS];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 1; i <= NUM_STRIPS; i++) begin
                occ[i] <= 8'd0;
            end
        end else if (wr_en && (wr_idx >= 4'd1) && (int'(wr_idx) <= NUM_STRIPS)) begin
            occ[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = 8'd0;
        if ((rd_idx >= 4'd1) && (int'(rd_idx) <= NUM_STRIPS)) begin
            rd_data = occ[rd_idx];
        end
    end

endmodule

// File: rtl/strip_placement_ctrl.sv
// -----------------------------------------------------------------------------
// strip_placement_ctrl
// Sequential best-fit strip scheduler. Accepts one (width, height) request,
// scans every strip one per cycle, picks the fitting strip with the smallest
// height (lowest ID on ties), advances that strip's occupancy and returns the
// strip ID, its previous occupancy (x start) and a consecutive-failure strike.
//   clk, rst : clock, synchronous active-high reset
//   clear    : frame clear (honoured in IDLE only)
//   busy     : high whenever the scheduler is not IDLE
//   bus      : request/result handshake (slave modport)
// -----------------------------------------------------------------------------
module strip_placement_ctrl
    import placement_pkg::*;
#(
    parameter int NUM_STRIPS = placement_pkg::NUM_STRIPS,
    parameter int STRIP_W    = placement_pkg::STRIP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    output logic                   busy,
    strip_placement_ctrl_if.slave  bus
);

    logic [1:0] state;
    logic [3:0] idx;
    logic [3:0] best;
    logic [7:0] w_q;
    logic [7:0] h_q;
    logic [3:0] fail_cnt;

    logic       res_valid;
    logic [3:0] res_strip_id;
    logic [7:0] res_occ_w;
    logic [3:0] res_strike;

    logic [3:0] rd_idx;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [8:0] occ_sum;
    logic       fits;
    logic       take;
    logic       req_legal;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // The single read port serves the scan in SCAN and the chosen strip in
    // DECIDE.
    assign rd_idx  = (state == ST_DECIDE) ? best : idx;

    // 9-bit sum so a full strip plus a 128-wide program cannot wrap.
    assign occ_sum = {1'b0, rd_data} + {1'b0, w_q};
    assign fits    = (strip_height(idx) >= h_q) && (occ_sum <= 9'(STRIP_W));
    // Strict less-than keeps the lower ID on equal heights.
    assign take    = fits && ((best == 4'd0) || (strip_height(idx) < strip_height(best)));

    assign wr_en   = (state == ST_DECIDE) && (best != 4'd0);
    assign wr_data = rd_data + w_q;

    assign req_legal = (bus.req_width  != 8'd0) && (bus.req_width  <= 8'(STRIP_W)) &&
                       (bus.req_height != 8'd0) && (bus.req_height <= 8'(STRIP_W));

    strip_occ_regs #(
        .NUM_STRIPS (NUM_STRIPS)
    ) u_occ (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == ST_IDLE) && clear),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (best),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= 4'd0;
            best         <= 4'd0;
            w_q          <= 8'd0;
            h_q          <= 8'd0;
            fail_cnt     <= 4'd0;
            res_valid    <= 1'b0;
            res_strip_id <= 4'd0;
            res_occ_w    <= 8'd0;
            res_strike   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        fail_cnt <= 4'd0;
                    end else if (bus.req_valid) begin
                        w_q   <= bus.req_width;
                        h_q   <= bus.req_height;
                        idx   <= 4'd1;
                        best  <= 4'd0;
                        state <= req_legal ? ST_SCAN : ST_DECIDE;
                    end
                end
                ST_SCAN: begin
                    if (take) begin
                        best <= idx;
                    end
                    if (idx == 4'(NUM_STRIPS)) begin
                        state <= ST_DECIDE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ST_DECIDE: begin
                    if (best != 4'd0) begin
                        res_strip_id <= best;
                        res_occ_w    <= rd_data;
                        res_strike   <= 4'd0;
                        fail_cnt     <= 4'd0;
                    end else begin
                        res_strip_id <= 4'd0;
                        res_occ_w    <= 8'd0;
                        res_strike   <= sat_inc(fail_cnt);
                        fail_cnt     <= sat_inc(fail_cnt);
                    end
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                default: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready          = (state == ST_IDLE) && !clear && !rst;
    assign bus.res_valid          = res_valid;
    assign bus.res_strip_id       = res_strip_id;
    assign bus.res_occupied_width = res_occ_w;
    assign bus.res_strike         = res_strike;
    assign busy                   = (state != ST_IDLE);

endmodule

// File: doc/strip_placement_ctrl.md
# strip_placement_ctrl

Sequential placement scheduler for the multi-program placement engine. It accepts one program placement request at a time (width, height) and scans the 13 fixed-height strips of the 128×128 region to choose a best-fit strip. It updates that strip's occupied-width register and returns `strip_id`, `occupied_width` and `strike`, which feed the (x, y) index stage directly. It owns the only copy of per-strip occupancy state.

## Interface
- `NUM_STRIPS`, default 13: number of strips; IDs are 1..NUM_STRIPS, and 0 means none.
- `STRIP_W`, default 128: strip width in placement units.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `clear` in 1: frame clear; empties all strips and zeroes the fail counter.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on `req_valid && req_ready`.
- `req_width` in 8: program width, legal range 1..128.
- `req_height` in 8: program height, legal range 1..128.
- `res_valid` out 1: result present.
- `res_ready` in 1: result consumed on `res_valid && res_ready`.
- `res_strip_id` out 4: chosen strip ID; 0 on failure.
- `res_occupied_width` out 8: strip occupancy before this placement, i.e. the x start (0-based); 0 on failure.
- `res_strike` out 4: 0 on success; saturating consecutive-failure count (1..15) on failure.
- `busy` out 1: high when state ≠ IDLE.

## Operation
- Strip heights, IDs 1..13: 8, 8, 9, 7, 10, 6, 11, 5, 12, 4, 16, 16, 16 (y bases 0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112).
- Occupancy registers: `occ[1..13]`, 8 bits each, range 0..128; `fail_cnt`, 4 bits, saturating at 15.
- FSM states:
  - IDLE:
    - `req_ready = !clear && !rst`.
    - `clear` has priority: all `occ` and `fail_cnt` go to 0, no request is accepted that cycle, and the state stays IDLE.
    - On an accept, latch width/height, set `idx = 1`, `best = 0`.
      - If width or height is 0, or either exceeds 128, go to DECIDE with `best = 0`.
      - Otherwise go to SCAN.
  - SCAN: one strip per cycle.
    - Strip `idx` fits when `H[idx] >= h` and `occ[idx] + w <= 128`, computed as a 9-bit sum.
    - If it fits and (`best == 0` or `H[idx] < H[best]`), set `best = idx`. Ties keep the lower ID.
    - If `idx == NUM_STRIPS`, go to DECIDE; otherwise `idx++`.
  - DECIDE: one cycle.
    - If `best ≠ 0`:
      - `res_strip_id = best`.
      - `res_occupied_width = occ[best]`.
      - `occ[best] += w`.
      - `res_strike = 0`.
      - `fail_cnt = 0`.
    - Otherwise:
      - `fail_cnt = sat(fail_cnt + 1)`.
      - `res_strike` = the new `fail_cnt`.
      - `res_strip_id = 0`.
      - `res_occupied_width = 0`.
    - Go to RESP.
  - RESP:
    - `res_valid = 1`; the `res_*` outputs are held stable.
    - On `res_ready`, return to IDLE.
- `clear` is ignored outside IDLE.

## Timing
- Reset values: state IDLE, every `occ` 0, `fail_cnt` 0, `res_valid` 0, all `res_*` 0, `busy` 0. `req_ready` is 0 while `rst` is high.
- Legal request accepted at edge T: SCAN occupies T+1..T+13, DECIDE is T+14, and `res_valid` is first seen high after edge T+15 (15 cycles of latency).
- Illegal request: `res_valid` is high after edge T+2.
- `res_ready` already high at the first RESP cycle: `res_valid` drops after 1 cycle and `req_ready` rises in the same cycle it drops.
- Throughput: one request per 16 cycles minimum.
- `rst` asserted in any state: next edge gives IDLE with all registers cleared. The in-flight request is dropped with no result.
- `res_*` are registered outputs, never combinational from the request inputs.

## Structure
- Shared package `placement_pkg`:
  - `NUM_STRIPS`, `STRIP_W`.
  - Strip height table and y-base table; the index stage must use the same table.
  - FSM state enum.
- Sub-module `strip_occ_regs`:
  - Array of 13×8-bit registers.
  - One combinational read port indexed by `idx`, one write port (index, data, enable), synchronous clear.
  - Reset via `rst`.
- The scan comparator, best-fit tracker and FSM stay in the top module.

## Test plan
- After reset, send w=20, h=8: strip 1, x=0, strike 0, `res_valid` 15 cycles after accept. Repeat: strip 1, x=20.
- Send w=30, h=10: strip 5 (height 10 is the best fit), x=0. Then h=13: strip 11.
- Send w=128, h=16 three times: strips 11, 12, 13, each x=0. Fourth identical request: strip 0, strike 1; fifth: strike 2. Then w=10, h=4: strip 10, strike 0.
- Send w=0, h=5: failure with strike 1, `res_valid` 2 cycles after accept, no `occ` changed.
- Hold `res_ready` low for 5 cycles with `req_valid` and `clear` pulsed: outputs stable, `req_ready` 0, clear has no effect. Then `clear` together with `req_valid` in IDLE: no accept, and the next w=20, h=8 gets strip 1 with x=0.
- Assert `rst` at SCAN cycle 6: no result ever produced, `busy` 0 on the next cycle, occupancy cleared (the next request lands at x=0).
